// File: rtl/servo_pkg.sv
// Shared definitions for the MMCM phase-shift servo controller.
//   servo_state_t : sequencing FSM states
//   STEP_W        : width of the signed net step counter
//   STEP_MAX/MIN  : saturation limits of the step counter
//   tmo_width()   : bit width needed for the PSDONE timeout counter
package servo_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        FILL,
        EVAL,
        PS_REQ,
        PS_WAIT
    } servo_state_t;

    localparam int unsigned STEP_W = 16;
    localparam logic signed [STEP_W-1:0] STEP_MAX = 16'sh7FFF;
    localparam logic signed [STEP_W-1:0] STEP_MIN = 16'sh8000;

    function automatic int unsigned tmo_width(input int unsigned limit);
        return (limit < 2) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/ce_divider.sv
// Clock-enable divider: emits a registered one-cycle tick every DECIM
// cycles while run is high. clear holds the count (and tick) at zero.
//   clk, reset_in_n : clock, async active-low reset
//   run             : advance the divider
//   clear           : synchronous clear, dominates run
//   tick            : one-cycle strobe, first one DECIM cycles after run starts
module ce_divider #(
    parameter int unsigned DECIM = 16
) (
    input  logic clk,
    input  logic reset_in_n,
    input  logic run,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CW = $clog2(DECIM);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset_in_n) begin
        if (!reset_in_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (clear) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (run) begin
            if (cnt == CW'(DECIM - 1)) begin
                cnt  <= '0;
                tick <= 1'b1;
            end else begin
                cnt  <= cnt + CW'(1);
                tick <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/mmcm_ps_servo_ctrl.sv
// Sequencing controller for the moving-average phase-error filter of the
// MMCM servo loop. Strobes/resets the filter, waits for it to fill, compares
// the averaged error to a deadband and issues single MMCM DPS steps.
//   clk         : clock (also MMCM PSCLK)
//   reset_in_n  : async active-low reset
//   enable      : run the servo while high
//   filt_out    : signed averaged phase error from the filter
//   filt_ce     : filter sample strobe
//   filt_reset  : filter synchronous reset
//   psen        : one-cycle MMCM phase-shift request
//   psincdec    : step direction (1 = increment)
//   psdone      : MMCM step complete
//   locked      : error stayed inside the deadband LOCK_CNT evaluations
//   step_count  : signed, saturating net step count
//   timeout_err : sticky PSDONE timeout flag
module mmcm_ps_servo_ctrl
    import servo_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned SIZE       = 5,
    parameter int unsigned DECIM      = 16,
    parameter int unsigned THRESH     = 64,
    parameter int unsigned LOCK_CNT   = 4,
    parameter int unsigned PS_TIMEOUT = 1023
) (
    input  logic                     clk,
    input  logic                     reset_in_n,
    input  logic                     enable,
    input  logic signed [WIDTH-1:0]  filt_out,
    output logic                     filt_ce,
    output logic                     filt_reset,
    output logic                     psen,
    output logic                     psincdec,
    input  logic                     psdone,
    output logic                     locked,
    output logic signed [STEP_W-1:0] step_count,
    output logic                     timeout_err
);

    localparam int unsigned DEPTH  = 1 << SIZE;
    localparam int unsigned FILL_W = SIZE + 2;
    localparam int unsigned IB_W   = $clog2(LOCK_CNT + 1);
    localparam int unsigned TMO_W  = tmo_width(PS_TIMEOUT);

    localparam logic signed [WIDTH-1:0] THR_POS = WIDTH'(THRESH);
    localparam logic signed [WIDTH-1:0] THR_NEG = -THR_POS;

    servo_state_t       state;
    logic [FILL_W-1:0]  fill_cnt;
    logic [IB_W-1:0]    inband_cnt;
    logic [TMO_W-1:0]   tmo_cnt;
    logic               ce_run;

    assign ce_run = (state == FILL);

    ce_divider #(.DECIM(DECIM)) u_ce_divider (
        .clk        (clk),
        .reset_in_n (reset_in_n),
        .run        (ce_run),
        .clear      (!ce_run),
        .tick       (filt_ce)
    );

    always_ff @(posedge clk or negedge reset_in_n) begin
        if (!reset_in_n) begin
            state       <= IDLE;
            fill_cnt    <= '0;
            inband_cnt  <= '0;
            tmo_cnt     <= '0;
            filt_reset  <= 1'b1;
            psen        <= 1'b0;
            psincdec    <= 1'b0;
            locked      <= 1'b0;
            step_count  <= '0;
            timeout_err <= 1'b0;
        end else begin
            psen <= 1'b0;
            case (state)
                IDLE: begin
                    filt_reset <= 1'b1;
                    fill_cnt   <= '0;
                    inband_cnt <= '0;
                    tmo_cnt    <= '0;
                    locked     <= 1'b0;
                    if (enable && !timeout_err)
                        state <= FLUSH;
                end
                FLUSH: begin
                    fill_cnt <= '0;
                    if (!enable) begin
                        state  <= IDLE;
                        locked <= 1'b0;
                    end else begin
                        filt_reset <= 1'b0;
                        state      <= FILL;
                    end
                end
                FILL: begin
                    if (!enable) begin
                        state      <= IDLE;
                        filt_reset <= 1'b1;
                        locked     <= 1'b0;
                    end else if (filt_ce) begin
                        // D+2 strobes: D samples plus accumulator and output registers
                        if (fill_cnt == FILL_W'(DEPTH + 1)) begin
                            fill_cnt <= '0;
                            state    <= EVAL;
                        end else begin
                            fill_cnt <= fill_cnt + FILL_W'(1);
                        end
                    end
                end
                EVAL: begin
                    if (!enable) begin
                        state      <= IDLE;
                        filt_reset <= 1'b1;
                        locked     <= 1'b0;
                    end else if (filt_out > THR_POS) begin
                        psincdec <= 1'b1;
                        psen     <= 1'b1;
                        state    <= PS_REQ;
                    end else if (filt_out < THR_NEG) begin
                        psincdec <= 1'b0;
                        psen     <= 1'b1;
                        state    <= PS_REQ;
                    end else begin
                        if (inband_cnt < IB_W'(LOCK_CNT))
                            inband_cnt <= inband_cnt + IB_W'(1);
                        if (inband_cnt >= IB_W'(LOCK_CNT - 1))
                            locked <= 1'b1;
                        fill_cnt <= '0;
                        state    <= FILL;
                    end
                end
                PS_REQ: begin
                    inband_cnt <= '0;
                    locked     <= 1'b0;
                    tmo_cnt    <= '0;
                    state      <= PS_WAIT;
                end
                PS_WAIT: begin
                    if (psdone) begin
                        if (psincdec) begin
                            if (step_count != STEP_MAX)
                                step_count <= step_count + STEP_W'(1);
                        end else if (step_count != STEP_MIN) begin
                            step_count <= step_count - STEP_W'(1);
                        end
                        tmo_cnt  <= '0;
                        fill_cnt <= '0;
                        if (enable) begin
                            state <= FILL;
                        end else begin
                            state      <= IDLE;
                            filt_reset <= 1'b1;
                        end
                    end else if (tmo_cnt == TMO_W'(PS_TIMEOUT - 1)) begin
                        // flag lands on the PS_TIMEOUT-th edge after PS_WAIT entry
                        timeout_err <= 1'b1;
                        tmo_cnt     <= '0;
                        filt_reset  <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                default: begin
                    state      <= IDLE;
                    filt_reset <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmcm_ps_servo_ctrl.sv
// Directed and randomized bench for mmcm_ps_servo_ctrl with a round-level
// reference model (deadband decision, lock counting, saturating step count).
module tb_mmcm_ps_servo_ctrl;

    localparam int DECIM      = 16;
    localparam int DEPTH      = 32;
    localparam int NCE        = DEPTH + 2;
    localparam int THRESH     = 64;
    localparam int LOCK_CNT   = 4;
    localparam int PS_TIMEOUT = 1023;

    localparam int M_NORMAL = 0;
    localparam int M_DROP   = 1;
    localparam int M_HANG   = 2;
    localparam int M_RST    = 3;

    logic               clk = 1'b0;
    logic               reset_in_n;
    logic               enable;
    logic               psdone;
    logic signed [31:0] filt_out;
    logic               filt_ce;
    logic               filt_reset;
    logic               psen;
    logic               psincdec;
    logic               locked;
    logic [15:0]        step_count;
    logic               timeout_err;

    int checks = 0;
    int errors = 0;
    int m_inband = 0;
    int m_steps = 0;

    always #5 clk = ~clk;

    mmcm_ps_servo_ctrl #(
        .WIDTH      (32),
        .SIZE       (5),
        .DECIM      (DECIM),
        .THRESH     (THRESH),
        .LOCK_CNT   (LOCK_CNT),
        .PS_TIMEOUT (PS_TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset_in_n  (reset_in_n),
        .enable      (enable),
        .filt_out    (filt_out),
        .filt_ce     (filt_ce),
        .filt_reset  (filt_reset),
        .psen        (psen),
        .psincdec    (psincdec),
        .psdone      (psdone),
        .locked      (locked),
        .step_count  (step_count),
        .timeout_err (timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outs(input string p);
        chk({p, "_filt_reset"}, filt_reset, 1);
        chk({p, "_filt_ce"}, filt_ce, 0);
        chk({p, "_psen"}, psen, 0);
        chk({p, "_psincdec"}, psincdec, 0);
        chk({p, "_locked"}, locked, 0);
        chk({p, "_timeout_err"}, timeout_err, 0);
        chk({p, "_step_count"}, step_count, 0);
    endtask

    // Called at a sample point with the DUT idle; returns at FILL entry.
    task automatic start_run();
        enable = 1'b1;
        tick();
        chk("flush_filt_reset", filt_reset, 1);
        chk("flush_filt_ce", filt_ce, 0);
        tick();
    endtask

    // One fill/evaluate round, starting at the first FILL cycle.
    task automatic do_round(input int val, input int dly, input int mode);
        int          bad;
        bit          up;
        logic [15:0] exp_sc;
        filt_out = val;
        bad = 0;
        for (int j = 0; j <= NCE * DECIM; j++) begin
            if (filt_ce !== ((j > 0) && (j % DECIM == 0))) bad++;
            if (psen !== 1'b0) bad++;
            if (filt_reset !== 1'b0) bad++;
            tick();
        end
        chk("fill_ce_pattern", bad, 0);
        chk("eval_psen", psen, 0);
        tick();
        exp_sc = m_steps[15:0];
        if (val <= THRESH && val >= -THRESH) begin
            m_inband = (m_inband < LOCK_CNT) ? m_inband + 1 : LOCK_CNT;
            chk("band_psen", psen, 0);
            chk("band_locked", locked, (m_inband >= LOCK_CNT) ? 1 : 0);
            chk("band_step_count", step_count, exp_sc);
            return;
        end
        up = (val > THRESH);
        chk("req_psen", psen, 1);
        chk("req_psincdec", psincdec, up);
        chk("req_locked_prior", locked, (m_inband >= LOCK_CNT) ? 1 : 0);
        tick();
        m_inband = 0;
        chk("wait_psen_pulse", psen, 0);
        chk("wait_locked", locked, 0);
        if (mode == M_DROP) enable = 1'b0;
        if (mode == M_HANG) begin
            bad = 0;
            for (int k = 1; k <= PS_TIMEOUT; k++) begin
                tick();
                if (timeout_err !== (k == PS_TIMEOUT)) bad++;
                if (psen !== 1'b0) bad++;
            end
            chk("timeout_timing", bad, 0);
            chk("timeout_flag", timeout_err, 1);
            chk("timeout_filt_reset", filt_reset, 1);
            return;
        end
        if (mode == M_RST) begin
            repeat (5) tick();
            #2 reset_in_n = 1'b0;
            #1;
            check_reset_outs("rst_mid_wait");
            m_steps = 0;
            m_inband = 0;
            return;
        end
        bad = 0;
        for (int k = 2; k <= dly; k++) begin
            tick();
            if (psen !== 1'b0) bad++;
            if (psincdec !== up) bad++;
            if (step_count !== exp_sc) bad++;
        end
        chk("wait_stable", bad, 0);
        psdone = 1'b1;
        tick();
        psdone = 1'b0;
        m_steps = up ? ((m_steps < 32767) ? m_steps + 1 : m_steps)
                     : ((m_steps > -32768) ? m_steps - 1 : m_steps);
        exp_sc = m_steps[15:0];
        chk("done_step_count", step_count, exp_sc);
        chk("done_psincdec_held", psincdec, up);
        chk("done_psen", psen, 0);
        chk("done_filt_reset", filt_reset, (mode == M_DROP) ? 1 : 0);
    endtask

    initial begin
        int bad;
        int val;
        int sel;
        reset_in_n = 1'b0;
        enable     = 1'b0;
        psdone     = 1'b0;
        filt_out   = '0;
        tick();
        tick();
        check_reset_outs("por");
        #2 reset_in_n = 1'b1;
        tick();
        check_reset_outs("idle");

        // In-band: lock after LOCK_CNT evaluations, no steps.
        start_run();
        for (int r = 0; r < LOCK_CNT; r++) do_round(10, 12, M_NORMAL);

        // Positive step, then inclusive band edges and a negative step.
        do_round(100, 12, M_NORMAL);
        do_round(64, 12, M_NORMAL);
        do_round(-64, 12, M_NORMAL);
        do_round(-65, 7, M_NORMAL);

        // Randomized rounds, biased toward the deadband edges.
        for (int r = 0; r < 6; r++) begin
            if (r % 2 == 0) begin
                sel = int'($urandom_range(3, 0));
                val = (sel == 0) ? 65 : (sel == 1) ? -65 : (sel == 2) ? 64 : -64;
            end else begin
                val = int'($urandom_range(300, 0)) - 150;
            end
            do_round(val, int'($urandom_range(20, 2)), M_NORMAL);
        end

        // Re-lock, then drop enable mid-FILL.
        for (int r = 0; r < LOCK_CNT; r++) do_round(0, 2, M_NORMAL);
        chk("relocked", locked, 1);
        repeat (100) tick();
        enable = 1'b0;
        tick();
        m_inband = 0;
        chk("drop_fill_filt_reset", filt_reset, 1);
        chk("drop_fill_locked", locked, 0);
        bad = 0;
        repeat (40) begin
            tick();
            if (filt_ce !== 1'b0 || filt_reset !== 1'b1) bad++;
        end
        chk("drop_fill_idle", bad, 0);

        // Enable drop during PS_WAIT: handshake completes, then IDLE.
        start_run();
        do_round(100, 12, M_DROP);
        bad = 0;
        repeat (40) begin
            tick();
            if (filt_ce !== 1'b0 || filt_reset !== 1'b1 || psen !== 1'b0) bad++;
        end
        chk("drop_wait_idle", bad, 0);

        // Async reset mid-PS_WAIT, then a late psdone is ignored.
        start_run();
        do_round(-100, 12, M_RST);
        enable = 1'b0;
        tick();
        #2 reset_in_n = 1'b1;
        tick();
        psdone = 1'b1;
        repeat (3) tick();
        psdone = 1'b0;
        tick();
        chk("late_psdone_step_count", step_count, 0);
        chk("late_psdone_psen", psen, 0);
        chk("late_psdone_filt_reset", filt_reset, 1);

        // PSDONE timeout, sticky flag blocks re-enable until reset.
        start_run();
        do_round(100, 0, M_HANG);
        bad = 0;
        repeat (600) begin
            tick();
            if (filt_reset !== 1'b1 || filt_ce !== 1'b0 || psen !== 1'b0 || timeout_err !== 1'b1) bad++;
        end
        chk("timeout_blocks_enable", bad, 0);
        enable = 1'b0;
        #2 reset_in_n = 1'b0;
        #1;
        check_reset_outs("rst_after_timeout");
        tick();
        #2 reset_in_n = 1'b1;
        tick();
        m_inband = 0;
        m_steps = 0;
        start_run();
        do_round(-20, 2, M_NORMAL);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mmcm_ps_servo_ctrl.md
# mmcm_ps_servo_ctrl

Sequencing controller for the moving-average phase-error filter in the MMCM servo loop. It generates the filter's sample strobe and reset, waits for the filter pipeline to fill, and compares the averaged error against a deadband. It issues single MMCM dynamic phase-shift steps (PSEN/PSINCDEC/PSDONE handshake) and reports lock. It sits between the phase detector/filter pair and the MMCM DPS port.

## Interface
- `WIDTH`, 32, filter data width (signed).
- `SIZE`, 5, filter depth log2; depth D = 2**SIZE.
- `DECIM`, 16, clk cycles per filter CE strobe (>= 2).
- `THRESH`, 64, deadband half-width, positive, fits in WIDTH-1 bits.
- `LOCK_CNT`, 4, consecutive in-band evaluations required for lock.
- `PS_TIMEOUT`, 1023, max cycles waiting for PSDONE.

Ports:
- `clk` in 1: single clock. Also the MMCM PSCLK.
- `reset_in_n` in 1: asynchronous, active-low reset.
- `enable` in 1: run servo while high.
- `filt_out` in WIDTH: signed averaged error from filter.
- `filt_ce` out 1: filter sample strobe.
- `filt_reset` out 1: filter synchronous active-high reset.
- `psen` out 1: MMCM phase-shift enable, one-cycle pulse.
- `psincdec` out 1: step direction (1 = increment).
- `psdone` in 1: MMCM step complete.
- `locked` out 1: loop inside deadband.
- `step_count` out 16: signed net steps issued.
- `timeout_err` out 1: sticky PSDONE timeout flag.

## Operation
- Reset values:
  - `filt_reset`=1.
  - `filt_ce`, `psen`, `psincdec`, `locked`, `timeout_err` = 0.
  - `step_count`=0.
  - State IDLE; all counters 0.
- States and transitions:
  - IDLE: `filt_reset`=1, CE divider held at 0. Leave for FLUSH when `enable`=1 and `timeout_err`=0.
  - FLUSH: `filt_reset`=1 for exactly one cycle, then FILL.
  - FILL: CE divider runs. `filt_ce` pulses one cycle when divider == DECIM-1. After D+2 CE pulses, go to EVAL. The extra two pulses cover the accum and output registers.
  - EVAL: one cycle, compares signed `filt_out`.
    - `filt_out > THRESH`: `psincdec`=1, go to PS_REQ.
    - `filt_out < -THRESH`: `psincdec`=0, go to PS_REQ.
    - Otherwise (inclusive band): increment in-band counter (saturating at LOCK_CNT); `locked`=1 once it reaches LOCK_CNT; go to FILL with fill counter cleared.
  - PS_REQ: `psen`=1 for this single cycle; clear in-band counter and `locked`; go to PS_WAIT.
  - PS_WAIT: `psincdec` held stable.
    - `psdone`=1: update `step_count` by ±1, saturating at +32767/-32768; go to FILL with fill counter cleared and no filter reset, so stale samples are flushed by refill.
    - Timeout counter reaches PS_TIMEOUT: set `timeout_err`, go to IDLE.
- Arithmetic: THRESH and -THRESH are formed as WIDTH-bit signed constants; all comparisons are signed.
- `enable` low:
  - In FLUSH, FILL or EVAL: go to IDLE next cycle and clear `locked`.
  - In PS_REQ/PS_WAIT: complete the handshake (or time out) first, then go to IDLE. An MMCM step is never abandoned.
- `psdone` outside PS_WAIT is ignored.
- `timeout_err` clears only on reset.
- Asynchronous reset mid-step returns all outputs to reset values immediately.

## Timing
- `filt_ce` period is exactly DECIM cycles. The first pulse is DECIM cycles after FILL entry.
- Enable-to-first-EVAL latency: 1 (IDLE→FLUSH) + 1 (FLUSH) + (D+2)·DECIM cycles.
- EVAL→`psen` high: next cycle.
- `psdone` high in cycle N: `step_count` updated and FILL entered at N+1.
- `locked` rises in the cycle after the LOCK_CNT-th in-band EVAL.
- All outputs are registered.

## Structure
- Package `servo_pkg`:
  - State enum (IDLE, FLUSH, FILL, EVAL, PS_REQ, PS_WAIT).
  - Step-count width (16) and saturation limits.
  - Timeout counter width function.
- Sub-module `ce_divider`:
  - Parameter DECIM; inputs `run`/`clear`; output one-cycle `tick`.
  - Instantiated once to drive `filt_ce`.
- Fill counter, in-band counter, timeout counter and FSM live in the top level.

## Test plan
- Band: `filt_out`=+10, `enable` rises, defaults, DECIM=16, D=32.
  - `filt_ce` ticks every 16 cycles; no `psen`.
  - First EVAL at cycle 546.
  - `locked`=1 after the 4th EVAL; `step_count`=0.
- Positive step: `filt_out`=+100, `psdone` returned 12 cycles after `psen`.
  - One-cycle `psen` with `psincdec`=1.
  - `step_count`=1; refill of 34 CEs before the next `psen`.
- Negative/boundary:
  - `filt_out`=-65 → `psincdec`=0, `step_count` decrements.
  - `filt_out`=±64 → no step (inclusive band).
- Timeout: `filt_out`=+100, `psdone` never asserted.
  - `timeout_err`=1 exactly 1023 cycles after PS_WAIT entry; state IDLE; `filt_reset`=1.
  - Re-enable blocked until reset.
- Enable drop:
  - Dropped in FILL: IDLE next cycle, `locked`=0.
  - Dropped during PS_WAIT: handshake completes, `step_count` updated, then IDLE.
- Async reset:
  - `reset_in_n` low mid-PS_WAIT: all outputs at reset values in the same cycle.
  - Late `psdone` after reset release is ignored.
